sequence_generator_1011: RTL and testbench
==========================================

SEQUENCE_GENERATOR_1011 -- requirements
Module: sequence_generator_1011

Interface
REQ-001 Parameter: PAT_WIDTH, default 4, pattern length in bits (min 2).
REQ-002 Parameter: DEFAULT_PATTERN, default 4'b1011, pattern used when pattern_in is all-zero at start.
REQ-003 Parameter: CNT_WIDTH, default 8, width of repeat_count.
REQ-004 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-005 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port: start  input  1  request to transmit; sampled only in IDLE.
REQ-007 Port: pattern_in  input  PAT_WIDTH  pattern to serialize, MSB first.
REQ-008 Port: repeat_count  input  CNT_WIDTH  number of pattern frames to emit.
REQ-009 Port: abort  input  1  synchronous cancel of transmission.
REQ-010 Port: sequence_out  output  1  serial bit, registered.
REQ-011 Port: out_valid  output  1  high when sequence_out carries a pattern bit.
REQ-012 Port: busy  output  1  high in any state other than IDLE.
REQ-013 Port: done  output  1  one-cycle pulse on normal completion.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT, GAP, DONE; all outputs registered.
REQ-015 IDLE: sequence_out=0, out_valid=0, busy=0, done=0.
REQ-016 start=1 in IDLE at edge k SHALL latch pattern_in (DEFAULT_PATTERN if pattern_in==0) and repeat_count, and enter SHIFT with bit PAT_WIDTH-1 on sequence_out, out_valid=1, after edge k.
REQ-017 SHIFT SHALL emit one bit per cycle, MSB to LSB, using a down-counting bit index.
REQ-018 After bit 0, the frame counter SHALL decrement; if nonzero, the next state SHALL be GAP (GAP_INSERT_EN defined) or SHIFT at bit PAT_WIDTH-1 (back-to-back, no idle cycle).
REQ-019 After bit 0 of the final frame, the next state SHALL be DONE: done=1, out_valid=0, sequence_out=0 for exactly one cycle, then IDLE.
REQ-020 repeat_count=0 at start SHALL go directly to DONE (no valid bits), then IDLE.
REQ-021 start while busy SHALL be ignored; latched pattern/count SHALL not change mid-transmission.
REQ-022 abort=1 in any non-IDLE state SHALL force IDLE at the next edge with outputs as REQ-015 and no done pulse; abort in IDLE has no effect.
REQ-023 abort and start both high in IDLE: abort SHALL win and start SHALL be ignored.
REQ-024 Bits emitted per run SHALL equal repeat_count*PAT_WIDTH exactly; the frame counter SHALL not wrap.

Reset
REQ-025 reset_n=0 SHALL immediately force IDLE, sequence_out=0, out_valid=0, busy=0, done=0, and clear latched pattern, bit index, and frame counter, regardless of clock.
REQ-026 Reset assertion mid-frame SHALL truncate output with no done pulse; first start after deassertion SHALL behave as REQ-016.

Configuration
REQ-027 Macro SEQGEN_GAP_INSERT_EN defined: one GAP cycle (sequence_out=0, out_valid=0, busy=1) SHALL separate consecutive frames.
REQ-028 Macro SEQGEN_GAP_INSERT_EN undefined: GAP state SHALL not exist and frames SHALL be back-to-back.

Verification
REQ-029 pattern_in=0, repeat_count=1, start pulse -> sequence_out 1,0,1,1 with out_valid=1 for 4 cycles, then done=1 for 1 cycle, busy=0 after.
REQ-030 pattern_in=4'b1011, repeat_count=3, gap enabled -> valid bits 1011,1011,1011 with one out_valid=0 gap between frames; 14 busy cycles before DONE; gap disabled -> 12 contiguous valid bits.
REQ-031 repeat_count=0, start -> no out_valid, done=1 on the cycle after start, then IDLE.
REQ-032 pattern_in=4'b1100, repeat_count=2, abort on 3rd bit -> out_valid=0 next cycle, busy=0, done never asserted.
REQ-033 reset_n pulled low between clock edges mid-frame -> outputs 0 immediately, no done; new start with repeat_count=1 emits 4 correct bits.
REQ-034 start re-pulsed with pattern_in=4'b0110 during a 1011 run -> run completes emitting 1011 only.

Source files
------------

// File: rtl/sequence_generator_1011.sv
// sequence_generator_1011
//   Serializes a latched PAT_WIDTH-bit pattern MSB first, repeating it for
//   repeat_count frames. It then emits a one-cycle done pulse and returns to idle.
//   All outputs are registered: each is computed from the next state and
//   loaded on the same edge as the state itself.
//
// Optional feature: define SEQGEN_GAP_INSERT_EN to insert one idle GAP cycle
//   (sequence_out=0, out_valid=0, busy=1) between consecutive frames. Without
//   the macro the GAP state does not exist and frames run back-to-back.
//
// Ports:
//   clock         rising-edge clock
//   reset_n       asynchronous active-low reset
//   start         transmit request, honoured only in IDLE
//   pattern_in    pattern to send (all-zero selects DEFAULT_PATTERN)
//   repeat_count  number of frames to send (0 -> straight to DONE)
//   abort         synchronous cancel; returns to IDLE without done
//   sequence_out  serial data bit
//   out_valid     sequence_out carries a pattern bit
//   busy          any state other than IDLE
//   done          one-cycle pulse on normal completion
module sequence_generator_1011 #(
  parameter int                      PAT_WIDTH       = 4,
  parameter logic [PAT_WIDTH-1:0]    DEFAULT_PATTERN = 4'b1011,
  parameter int                      CNT_WIDTH       = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [PAT_WIDTH-1:0] pattern_in,
  input  logic [CNT_WIDTH-1:0] repeat_count,
  input  logic                 abort,
  output logic                 sequence_out,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int IDX_W = $clog2(PAT_WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
`ifdef SEQGEN_GAP_INSERT_EN
    ,GAP  = 2'd3
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [PAT_WIDTH-1:0] pat_q, pat_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic                 sequence_out_q, sequence_out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [PAT_WIDTH-1:0] start_pat;
  logic [IDX_W-1:0]     idx_dec;

  assign start_pat = (pattern_in == '0) ? DEFAULT_PATTERN : pattern_in;
  assign idx_dec   = bit_idx_q - IDX_W'(1);

  always_comb begin
    state_d        = state_q;
    pat_d          = pat_q;
    bit_idx_d      = bit_idx_q;
    frame_cnt_d    = frame_cnt_q;
    sequence_out_d = 1'b0;
    out_valid_d    = 1'b0;
    busy_d         = 1'b0;
    done_d         = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Abort has priority over start, even in IDLE.
        if (start && !abort) begin
          pat_d       = start_pat;
          frame_cnt_d = repeat_count;
          bit_idx_d   = IDX_MSB;
          busy_d      = 1'b1;
          if (repeat_count == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d        = SHIFT;
            sequence_out_d = start_pat[IDX_MSB];
            out_valid_d    = 1'b1;
          end
        end
      end

      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (bit_idx_q != '0) begin
          bit_idx_d      = idx_dec;
          sequence_out_d = pat_q[idx_dec];
          out_valid_d    = 1'b1;
          busy_d         = 1'b1;
        end else begin
          // Last bit of a frame. frame_cnt_q is never zero here, so the
          // decrement cannot wrap.
          frame_cnt_d = frame_cnt_q - CNT_WIDTH'(1);
          bit_idx_d   = IDX_MSB;
          busy_d      = 1'b1;
          if (frame_cnt_q != CNT_WIDTH'(1)) begin
`ifdef SEQGEN_GAP_INSERT_EN
            state_d        = GAP;
`else
            state_d        = SHIFT;
            sequence_out_d = pat_q[IDX_MSB];
            out_valid_d    = 1'b1;
`endif
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

`ifdef SEQGEN_GAP_INSERT_EN
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d        = SHIFT;
          bit_idx_d      = IDX_MSB;
          sequence_out_d = pat_q[IDX_MSB];
          out_valid_d    = 1'b1;
          busy_d         = 1'b1;
        end
      end
`endif

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      pat_q          <= '0;
      bit_idx_q      <= '0;
      frame_cnt_q    <= '0;
      sequence_out_q <= 1'b0;
      out_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pat_q          <= pat_d;
      bit_idx_q      <= bit_idx_d;
      frame_cnt_q    <= frame_cnt_d;
      sequence_out_q <= sequence_out_d;
      out_valid_q    <= out_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign sequence_out = sequence_out_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_sequence_generator_1011.sv
// Directed bench for sequence_generator_1011 (default parameters).
// Outputs are compared as {sequence_out, out_valid, busy, done}, 1 time unit
// after each rising edge. Expected streams are hand-written constants.
module tb_sequence_generator_1011;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [3:0] pattern_in;
  logic [7:0] repeat_count;
  logic       abort;
  logic       sequence_out;
  logic       out_valid;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  sequence_generator_1011 dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .pattern_in   (pattern_in),
    .repeat_count (repeat_count),
    .abort        (abort),
    .sequence_out (sequence_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .done         (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {sequence_out, out_valid, busy, done};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed {seq,valid,busy,done}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Checks n busy cycles starting right after the start edge (MSB of the
  // constants first), then the DONE pulse and the return to IDLE.
  task automatic check_stream(input string tag, input logic [31:0] bits,
                              input logic [31:0] valid, input int n);
    for (int c = 0; c < n; c++) begin
      if (c > 0) tick();
      check($sformatf("%s_c%0d", tag, c), {bits[n-1-c], valid[n-1-c], 1'b1, 1'b0});
    end
    tick();
    check({tag, "_done"}, 4'b0011);
    tick();
    check({tag, "_idle"}, 4'b0000);
  endtask

  task automatic kick(input logic [3:0] pat, input logic [7:0] cnt);
    pattern_in   = pat;
    repeat_count = cnt;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    pattern_in   = 4'b0000;
    repeat_count = 8'd0;
    abort        = 1'b0;
    #2;
    check("reset_async", 4'b0000);
    tick();
    check("reset_held", 4'b0000);
    #2 reset_n = 1'b1;
    tick();
    check("idle_after_reset", 4'b0000);

    // Zero pattern selects 1011, one frame.
    kick(4'b0000, 8'd1);
    check_stream("default_pat", 32'b1011, 32'b1111, 4);
    $display("txn default_pat done");

    // Three frames of 1011.
    kick(4'b1011, 8'd3);
`ifdef SEQGEN_GAP_INSERT_EN
    check_stream("three_frames_gap", 32'b10110101101011, 32'b11110111101111, 14);
`else
    check_stream("three_frames", 32'b101110111011, 32'b111111111111, 12);
`endif
    $display("txn three_frames done");

    // repeat_count = 0: straight to DONE.
    kick(4'b1011, 8'd0);
    check("zero_cnt_done", 4'b0011);
    tick();
    check("zero_cnt_idle", 4'b0000);
    $display("txn zero_count done");

    // Abort on the third bit of 1100.
    kick(4'b1100, 8'd2);
    check("abort_b3", 4'b1110);
    tick();
    check("abort_b2", 4'b1110);
    tick();
    check("abort_b1", 4'b0110);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("abort_nodone_%0d", i), 4'b0000);
    end
    $display("txn abort done");

    // Abort together with start in IDLE: nothing starts.
    abort = 1'b1;
    kick(4'b1011, 8'd1);
    abort = 1'b0;
    check("abort_start_idle", 4'b0000);
    tick();
    check("abort_start_idle2", 4'b0000);
    $display("txn abort_with_start done");

    // Asynchronous reset mid-frame, then a clean restart.
    kick(4'b1011, 8'd2);
    check("rst_mid_b3", 4'b1110);
    tick();
    check("rst_mid_b2", 4'b0110);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_async", 4'b0000);
    tick();
    check("rst_mid_held", 4'b0000);
    #2 reset_n = 1'b1;
    tick();
    check("rst_mid_nodone", 4'b0000);
    kick(4'b1011, 8'd1);
    check_stream("after_reset", 32'b1011, 32'b1111, 4);
    $display("txn reset_mid_frame done");

    // Start re-pulsed with 0110 while sending 1011: ignored.
    kick(4'b1011, 8'd1);
    pattern_in   = 4'b0110;
    repeat_count = 8'd5;
    start        = 1'b1;
    check("restart_b3", 4'b1110);
    tick();
    check("restart_b2", 4'b0110);
    tick();
    start = 1'b0;
    check("restart_b1", 4'b1110);
    tick();
    check("restart_b0", 4'b1110);
    tick();
    check("restart_done", 4'b0011);
    tick();
    check("restart_idle", 4'b0000);
    $display("txn restart_ignored done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
